vga_timing: RTL and testbench

- Generates raster timing for the game-of-life display pipeline.
- Produces the pixel coordinate `x`/`y`, the `candraw` visible-area flag, and the `hsync`/`vsync` outputs.
- `x`, `y` and `candraw` feed the renderer directly. `hsync`/`vsync` go to the VGA DAC.
- Also emits a `vblank_start` pulse, which the life update engine uses to do board updates outside the visible area, and a running frame counter.

---
 rtl/vga_timing_if.sv | 23 ++
 rtl/vga_timing.sv | 111 +++++++++++
 tb/tb_vga_timing.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// Raster timing bundle between the timing generator (master) and its consumers
// (renderer, life update engine, VGA DAC).
interface vga_timing_if;
  logic        pix_en;
  logic [10:0] x;
  logic [10:0] y;
  logic        candraw;
  logic        hsync;
  logic        vsync;
  logic        start_of_frame;
  logic        vblank_start;
  logic [15:0] frame;

  modport master (
    input  pix_en,
    output x, y, candraw, hsync, vsync, start_of_frame, vblank_start, frame
  );

  modport slave (
    output pix_en,
    input  x, y, candraw, hsync, vsync, start_of_frame, vblank_start, frame
  );
endinterface

// File: rtl/vga_timing.sv
// Raster counter for the game-of-life display: pixel coordinates, visible-area flag,
// syncs, frame/vblank pulses and a running frame count, all registered and aligned.
module vga_timing #(
  parameter int unsigned H_VISIBLE    = 640,
  parameter int unsigned H_FRONT      = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BACK       = 48,
  parameter int unsigned V_VISIBLE    = 480,
  parameter int unsigned V_FRONT      = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BACK       = 33,
  parameter bit          HSYNC_ACTIVE = 1'b0,
  parameter bit          VSYNC_ACTIVE = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  vga_timing_if.master  vga
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 2047 || V_TOTAL > 2047 || H_TOTAL == 0 || V_TOTAL == 0) begin : g_param_check
    $error("vga_timing: H_TOTAL and V_TOTAL must be in 1..2047");
  end

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
  localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [10:0] hc_q, hc_d;
  logic [10:0] vc_q, vc_d;
  logic [15:0] frm_q, frm_d;

  logic [10:0] x_q, y_q;
  logic        candraw_q, hsync_q, vsync_q, sof_q, vbs_q;
  logic [15:0] frame_q;

  logic hs_act, vs_act;

  assign hs_act = (hc_q >= HS_BEG) && (hc_q < HS_END);
  assign vs_act = (vc_q >= VS_BEG) && (vc_q < VS_END);

  always_comb begin
    hc_d  = hc_q;
    vc_d  = vc_q;
    frm_d = frm_q;
    if (vga.pix_en) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        if (vc_q == V_LAST) begin
          vc_d  = '0;
          frm_d = frm_q + 16'd1;
        end else begin
          vc_d = vc_q + 11'd1;
        end
      end else begin
        hc_d = hc_q + 11'd1;
      end
    end
  end

  // Outputs are decoded from the pre-increment counters so every output names the same pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      hc_q      <= '0;
      vc_q      <= '0;
      frm_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      candraw_q <= 1'b0;
      hsync_q   <= ~HSYNC_ACTIVE;
      vsync_q   <= ~VSYNC_ACTIVE;
      sof_q     <= 1'b0;
      vbs_q     <= 1'b0;
      frame_q   <= '0;
    end else begin
      hc_q  <= hc_d;
      vc_q  <= vc_d;
      frm_q <= frm_d;
      if (vga.pix_en) begin
        x_q       <= hc_q;
        y_q       <= vc_q;
        candraw_q <= (hc_q < H_VIS) && (vc_q < V_VIS);
        hsync_q   <= hs_act ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
        vsync_q   <= vs_act ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
        sof_q     <= (hc_q == '0) && (vc_q == '0);
        vbs_q     <= (hc_q == '0) && (vc_q == V_VIS);
        frame_q   <= frm_q;
      end else begin
        sof_q <= 1'b0;
        vbs_q <= 1'b0;
      end
    end
  end

  assign vga.x              = x_q;
  assign vga.y              = y_q;
  assign vga.candraw        = candraw_q;
  assign vga.hsync          = hsync_q;
  assign vga.vsync          = vsync_q;
  assign vga.start_of_frame = sof_q;
  assign vga.vblank_start   = vbs_q;
  assign vga.frame          = frame_q;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: 640x480 timing (u_dut0), a 7x7 reduced build (u_dut1) for whole-frame
// behaviour, and a 1x1 build (u_dut2) that wraps the frame counter quickly.
module tb_vga_timing;
  logic clk = 1'b0;
  logic rst0, rst1, rst2;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  vga_timing_if vif0 ();
  vga_timing_if vif1 ();
  vga_timing_if vif2 ();

  vga_timing u_dut0 (.clk(clk), .rst(rst0), .vga(vif0));

  vga_timing #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) u_dut1 (.clk(clk), .rst(rst1), .vga(vif1));

  vga_timing #(
    .H_VISIBLE(1), .H_FRONT(0), .H_SYNC(0), .H_BACK(0),
    .V_VISIBLE(1), .V_FRONT(0), .V_SYNC(0), .V_BACK(0)
  ) u_dut2 (.clk(clk), .rst(rst2), .vga(vif2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    vif0.pix_en = 1'b1; vif1.pix_en = 1'b1; vif2.pix_en = 1'b1;
    tick(); tick();
    n_cmp++; if (vif0.x !== 11'd0) begin n_bad++; $display("FAIL reset_x got %0d want 0", vif0.x); end
    n_cmp++; if (vif0.y !== 11'd0) begin n_bad++; $display("FAIL reset_y got %0d want 0", vif0.y); end
    n_cmp++; if (vif0.candraw !== 1'b0) begin n_bad++; $display("FAIL reset_candraw got %b want 0", vif0.candraw); end
    n_cmp++; if (vif0.hsync !== 1'b1) begin n_bad++; $display("FAIL reset_hsync got %b want 1", vif0.hsync); end
    n_cmp++; if (vif0.vsync !== 1'b1) begin n_bad++; $display("FAIL reset_vsync got %b want 1", vif0.vsync); end
    n_cmp++; if (vif0.start_of_frame !== 1'b0) begin n_bad++; $display("FAIL reset_sof got %b want 0", vif0.start_of_frame); end
    n_cmp++; if (vif0.vblank_start !== 1'b0) begin n_bad++; $display("FAIL reset_vblank got %b want 0", vif0.vblank_start); end
    n_cmp++; if (vif0.frame !== 16'd0) begin n_bad++; $display("FAIL reset_frame got %0d want 0", vif0.frame); end
    rst2 = 1'b0;
  endtask

  task automatic test_line();
    int hs_low;
    int last_draw;
    logic exp_cd, exp_hs, exp_sof;
    hs_low = 0;
    last_draw = -1;
    rst0 = 1'b0;
    for (int i = 0; i < 800; i++) begin
      tick();
      exp_cd  = (i < 640);
      exp_hs  = !(i >= 656 && i < 752);
      exp_sof = (i == 0);
      n_cmp++; if (vif0.x !== 11'(i)) begin n_bad++; $display("FAIL line_x got %0d want %0d", vif0.x, i); end
      n_cmp++; if (vif0.y !== 11'd0) begin n_bad++; $display("FAIL line_y at x=%0d got %0d want 0", i, vif0.y); end
      n_cmp++; if (vif0.candraw !== exp_cd) begin n_bad++; $display("FAIL line_candraw at x=%0d got %b want %b", i, vif0.candraw, exp_cd); end
      n_cmp++; if (vif0.hsync !== exp_hs) begin n_bad++; $display("FAIL line_hsync at x=%0d got %b want %b", i, vif0.hsync, exp_hs); end
      n_cmp++; if (vif0.start_of_frame !== exp_sof) begin n_bad++; $display("FAIL line_sof at x=%0d got %b want %b", i, vif0.start_of_frame, exp_sof); end
      if (vif0.hsync === 1'b0) hs_low++;
      if (vif0.candraw === 1'b1) last_draw = i;
    end
    n_cmp++; if (hs_low != 96) begin n_bad++; $display("FAIL line_hsync_width got %0d want 96", hs_low); end
    n_cmp++; if (last_draw != 639) begin n_bad++; $display("FAIL line_last_candraw got %0d want 639", last_draw); end
    tick();
    n_cmp++; if (vif0.x !== 11'd0 || vif0.y !== 11'd1) begin n_bad++; $display("FAIL line_wrap got (%0d,%0d) want (0,1)", vif0.x, vif0.y); end
    n_cmp++; if (vif0.start_of_frame !== 1'b0) begin n_bad++; $display("FAIL line_wrap_sof got %b want 0", vif0.start_of_frame); end
  endtask

  task automatic test_hold();
    int hs_low;
    hs_low = 0;
    for (int i = 1; i <= 700; i++) begin
      tick();
      if (vif0.hsync === 1'b0) hs_low++;
    end
    n_cmp++; if (vif0.x !== 11'd700 || vif0.hsync !== 1'b0) begin n_bad++; $display("FAIL hold_setup got x=%0d hsync=%b want x=700 hsync=0", vif0.x, vif0.hsync); end
    vif0.pix_en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      n_cmp++; if (vif0.x !== 11'd700 || vif0.y !== 11'd1) begin n_bad++; $display("FAIL hold_xy got (%0d,%0d) want (700,1)", vif0.x, vif0.y); end
      n_cmp++; if (vif0.hsync !== 1'b0 || vif0.vsync !== 1'b1 || vif0.candraw !== 1'b0) begin n_bad++; $display("FAIL hold_flags got hs=%b vs=%b cd=%b want 0 1 0", vif0.hsync, vif0.vsync, vif0.candraw); end
    end
    vif0.pix_en = 1'b1;
    tick();
    if (vif0.hsync === 1'b0) hs_low++;
    n_cmp++; if (vif0.x !== 11'd701) begin n_bad++; $display("FAIL hold_resume_x got %0d want 701", vif0.x); end
    for (int i = 0; i < 99; i++) begin
      tick();
      if (vif0.hsync === 1'b0) hs_low++;
    end
    n_cmp++; if (hs_low != 96) begin n_bad++; $display("FAIL hold_hsync_total got %0d want 96", hs_low); end
    n_cmp++; if (vif0.x !== 11'd0 || vif0.y !== 11'd2) begin n_bad++; $display("FAIL hold_end got (%0d,%0d) want (0,2)", vif0.x, vif0.y); end
  endtask

  task automatic test_line_reset();
    for (int i = 0; i < 300; i++) tick();
    n_cmp++; if (vif0.x !== 11'd300 || vif0.y !== 11'd2) begin n_bad++; $display("FAIL lrst_setup got (%0d,%0d) want (300,2)", vif0.x, vif0.y); end
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    n_cmp++; if (vif0.x !== 11'd0 || vif0.y !== 11'd0 || vif0.candraw !== 1'b0) begin n_bad++; $display("FAIL lrst_xy got (%0d,%0d) cd=%b want (0,0) cd=0", vif0.x, vif0.y, vif0.candraw); end
    tick();
    n_cmp++; if (vif0.x !== 11'd0 || vif0.y !== 11'd0 || vif0.start_of_frame !== 1'b1 || vif0.candraw !== 1'b1) begin n_bad++; $display("FAIL lrst_restart got (%0d,%0d) sof=%b cd=%b want (0,0) 1 1", vif0.x, vif0.y, vif0.start_of_frame, vif0.candraw); end
  endtask

  task automatic test_pix_en_toggle();
    int e, ex, ey, ef, sof_cnt, vbs_cnt, prev_sof_k;
    logic exp_cd, exp_hs, exp_vs, exp_sof, exp_vbs;
    e = 0; ex = 0; ey = 0; ef = 0; sof_cnt = 0; vbs_cnt = 0; prev_sof_k = 0;
    rst1 = 1'b0;
    for (int k = 1; k <= 198; k++) begin
      vif1.pix_en = (k % 2 == 1);
      tick();
      if (k % 2 == 1) begin
        e++;
        ex = (e - 1) % 7;
        ey = ((e - 1) / 7) % 7;
        ef = (e - 1) / 49;
        exp_cd  = (ex < 4) && (ey < 4);
        exp_hs  = (ex != 5);
        exp_vs  = (ey != 5);
        exp_sof = (ex == 0) && (ey == 0);
        exp_vbs = (ex == 0) && (ey == 4);
        n_cmp++; if (vif1.x !== 11'(ex) || vif1.y !== 11'(ey)) begin n_bad++; $display("FAIL tog_xy got (%0d,%0d) want (%0d,%0d)", vif1.x, vif1.y, ex, ey); end
        n_cmp++; if (vif1.candraw !== exp_cd) begin n_bad++; $display("FAIL tog_candraw at (%0d,%0d) got %b want %b", ex, ey, vif1.candraw, exp_cd); end
        n_cmp++; if (vif1.hsync !== exp_hs || vif1.vsync !== exp_vs) begin n_bad++; $display("FAIL tog_sync at (%0d,%0d) got %b%b want %b%b", ex, ey, vif1.hsync, vif1.vsync, exp_hs, exp_vs); end
        n_cmp++; if (vif1.start_of_frame !== exp_sof || vif1.vblank_start !== exp_vbs) begin n_bad++; $display("FAIL tog_pulses at (%0d,%0d) got %b%b want %b%b", ex, ey, vif1.start_of_frame, vif1.vblank_start, exp_sof, exp_vbs); end
        n_cmp++; if (vif1.frame !== 16'(ef)) begin n_bad++; $display("FAIL tog_frame got %0d want %0d", vif1.frame, ef); end
      end else begin
        n_cmp++; if (vif1.start_of_frame !== 1'b0 || vif1.vblank_start !== 1'b0) begin n_bad++; $display("FAIL tog_idle_pulses got %b%b want 00", vif1.start_of_frame, vif1.vblank_start); end
        n_cmp++; if (vif1.x !== 11'(ex) || vif1.y !== 11'(ey)) begin n_bad++; $display("FAIL tog_idle_xy got (%0d,%0d) want (%0d,%0d)", vif1.x, vif1.y, ex, ey); end
      end
      if (vif1.vblank_start === 1'b1) vbs_cnt++;
      if (vif1.start_of_frame === 1'b1) begin
        sof_cnt++;
        if (prev_sof_k != 0) begin
          n_cmp++; if (k - prev_sof_k != 98) begin n_bad++; $display("FAIL tog_frame_clocks got %0d want 98", k - prev_sof_k); end
        end
        prev_sof_k = k;
      end
    end
    n_cmp++; if (sof_cnt != 3) begin n_bad++; $display("FAIL tog_sof_count got %0d want 3", sof_cnt); end
    n_cmp++; if (vbs_cnt != 2) begin n_bad++; $display("FAIL tog_vblank_count got %0d want 2", vbs_cnt); end
  endtask

  task automatic test_frame_reset();
    bit found;
    found = 1'b0;
    vif1.pix_en = 1'b1;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (vif1.x === 11'd5 && vif1.y === 11'd5) found = 1'b1;
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL frst_reach got (%0d,%0d) want (5,5)", vif1.x, vif1.y); end
    n_cmp++; if (vif1.hsync !== 1'b0 || vif1.vsync !== 1'b0 || vif1.frame !== 16'd2) begin n_bad++; $display("FAIL frst_setup got hs=%b vs=%b frame=%0d want 0 0 2", vif1.hsync, vif1.vsync, vif1.frame); end
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    n_cmp++; if (vif1.x !== 11'd0 || vif1.y !== 11'd0 || vif1.candraw !== 1'b0) begin n_bad++; $display("FAIL frst_xy got (%0d,%0d) cd=%b want (0,0) 0", vif1.x, vif1.y, vif1.candraw); end
    n_cmp++; if (vif1.hsync !== 1'b1 || vif1.vsync !== 1'b1) begin n_bad++; $display("FAIL frst_sync got %b%b want 11", vif1.hsync, vif1.vsync); end
    n_cmp++; if (vif1.frame !== 16'd0 || vif1.start_of_frame !== 1'b0) begin n_bad++; $display("FAIL frst_frame got %0d sof=%b want 0 0", vif1.frame, vif1.start_of_frame); end
    tick();
    n_cmp++; if (vif1.x !== 11'd0 || vif1.y !== 11'd0 || vif1.start_of_frame !== 1'b1 || vif1.candraw !== 1'b1) begin n_bad++; $display("FAIL frst_restart got (%0d,%0d) sof=%b cd=%b want (0,0) 1 1", vif1.x, vif1.y, vif1.start_of_frame, vif1.candraw); end
    tick();
    n_cmp++; if (vif1.x !== 11'd1 || vif1.start_of_frame !== 1'b0) begin n_bad++; $display("FAIL frst_next got x=%0d sof=%b want 1 0", vif1.x, vif1.start_of_frame); end
  endtask

  task automatic test_frame_wrap();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 70000 && !found; i++) begin
      if (vif2.frame === 16'hFFFF) found = 1'b1;
      else tick();
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL wrap_reach got %h want ffff", vif2.frame); end
    n_cmp++; if (vif2.start_of_frame !== 1'b1 || vif2.candraw !== 1'b1 || vif2.hsync !== 1'b1 || vif2.vsync !== 1'b1) begin n_bad++; $display("FAIL wrap_flags got sof=%b cd=%b hs=%b vs=%b want 1111", vif2.start_of_frame, vif2.candraw, vif2.hsync, vif2.vsync); end
    tick();
    n_cmp++; if (vif2.frame !== 16'h0000) begin n_bad++; $display("FAIL wrap_zero got %h want 0000", vif2.frame); end
    n_cmp++; if (vif2.x !== 11'd0 || vif2.y !== 11'd0 || vif2.start_of_frame !== 1'b1) begin n_bad++; $display("FAIL wrap_pixel got (%0d,%0d) sof=%b want (0,0) 1", vif2.x, vif2.y, vif2.start_of_frame); end
    tick();
    n_cmp++; if (vif2.frame !== 16'h0001) begin n_bad++; $display("FAIL wrap_one got %h want 0001", vif2.frame); end
  endtask

  initial begin
    test_reset();
    test_line();
    test_hold();
    test_line_reset();
    test_pix_en_toggle();
    test_frame_reset();
    test_frame_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
